// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin encodings, coin values and the
// change dispenser's state encoding.
package vending_pkg;

    localparam logic [1:0] PENNY   = 2'd0;
    localparam logic [1:0] NICKEL  = 2'd1;
    localparam logic [1:0] DIME    = 2'd2;
    localparam logic [1:0] QUARTER = 2'd3;

    localparam int PENNY_VAL   = 1;
    localparam int NICKEL_VAL  = 5;
    localparam int DIME_VAL    = 10;
    localparam int QUARTER_VAL = 25;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_DONE     = 2'd2,
        ST_JAM      = 2'd3
    } dispState_t;

endpackage

// File: rtl/coin_selector.sv
// Greedy denomination picker: the largest coin not exceeding the amount
// still owed, together with its value in cents.
module coin_selector
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] remaining,
    output logic [1:0]          coinType,
    output logic [CREDIT_W-1:0] coinValue
);

    always_comb begin
        coinType  = PENNY;
        coinValue = CREDIT_W'(PENNY_VAL);
        if (remaining >= CREDIT_W'(QUARTER_VAL)) begin
            coinType  = QUARTER;
            coinValue = CREDIT_W'(QUARTER_VAL);
        end else if (remaining >= CREDIT_W'(DIME_VAL)) begin
            coinType  = DIME;
            coinValue = CREDIT_W'(DIME_VAL);
        end else if (remaining >= CREDIT_W'(NICKEL_VAL)) begin
            coinType  = NICKEL;
            coinValue = CREDIT_W'(NICKEL_VAL);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin-return engine: latches the credit, clears the piggy bank, then pays the
// amount out one coin per handshake, declaring a jam if the ejector stalls.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 8,
    parameter int TIMEOUT  = 1000,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                returnReq,
    input  logic [CREDIT_W-1:0] credit,
    input  logic                coinReady,
    output logic                creditClear,
    output logic                coinValid,
    output logic [1:0]          coinType,
    output logic                busy,
    output logic [CNT_W-1:0]    coinCount,
    output logic                done,
    output logic                jam
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    dispState_t          state, stateNext;
    logic [CREDIT_W-1:0] remaining, remainingNext;
    logic [CREDIT_W-1:0] coinValue;
    logic [CNT_W-1:0]    countNext;
    logic [WAIT_W-1:0]   waitCnt, waitNext;
    logic                clearNext;
    logic [1:0]          selType;
    logic [CREDIT_W-1:0] selValue;

    // Selecting from the next remaining lets coinType/coinValue be registered
    // alongside remaining, so they are always valid for the coin on offer.
    coin_selector #(
        .CREDIT_W (CREDIT_W)
    ) u_selector (
        .remaining (remainingNext),
        .coinType  (selType),
        .coinValue (selValue)
    );

    always_comb begin
        stateNext     = state;
        remainingNext = remaining;
        countNext     = coinCount;
        waitNext      = waitCnt;
        clearNext     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (returnReq) begin
                    countNext = '0;
                    waitNext  = '0;
                    if (credit != '0) begin
                        remainingNext = credit;
                        clearNext     = 1'b1;
                        stateNext     = ST_DISPENSE;
                    end else begin
                        stateNext = ST_DONE;
                    end
                end
            end
            ST_DISPENSE: begin
                // coinValid is always high here, so coinReady alone marks a transfer
                if (coinReady) begin
                    remainingNext = remaining - coinValue;
                    countNext     = coinCount + 1'b1;
                    waitNext      = '0;
                    if (remainingNext == '0) begin
                        stateNext = ST_DONE;
                    end
                end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
                    stateNext = ST_JAM;
                end else begin
                    waitNext = waitCnt + 1'b1;
                end
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
            end
            ST_JAM: begin
                stateNext = ST_JAM;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            coinValue   <= '0;
            coinCount   <= '0;
            waitCnt     <= '0;
            creditClear <= 1'b0;
            coinValid   <= 1'b0;
            coinType    <= PENNY;
            busy        <= 1'b0;
            done        <= 1'b0;
            jam         <= 1'b0;
        end else begin
            state       <= stateNext;
            remaining   <= remainingNext;
            coinValue   <= selValue;
            coinCount   <= countNext;
            waitCnt     <= waitNext;
            creditClear <= clearNext;
            coinValid   <= (stateNext == ST_DISPENSE);
            coinType    <= selType;
            busy        <= (stateNext != ST_IDLE);
            done        <= (stateNext == ST_DONE);
            jam         <= (stateNext == ST_JAM);
        end
    end

endmodule
